// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 scan-code receiver: key event word, prefix codes, frame states.
// Pure declarations; no timing or flow control.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

   // PS/2 uses odd parity over the 8 data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
      return ^{dat, par};
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin sync, ps2_clk glitch filter, 11-bit frame FSM and in-frame watchdog.
// byte_valid/error pulse 1 cycle after the stop-bit strobe; no backpressure (device cannot be stalled).
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 10000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_dat,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_s;
   logic                   dat_s;

   logic [FW-1:0]          flt_cnt;
   logic                   clk_flt;
   logic                   strobe;

   ps2_rx_state_t          state;
   ps2_rx_state_t          state_nxt;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic                   par_bit;
   logic [WW-1:0]          wdog;
   logic                   timeout;
   logic                   good_c;
   logic                   perr_c;
   logic                   ferr_c;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];

   // A new clock level is accepted only after FILTER_LEN consecutive differing samples;
   // the strobe is raised in the same cycle the filtered clock drops.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         flt_cnt <= '0;
         clk_flt <= 1'b1;
         strobe  <= 1'b0;
      end else begin
         strobe <= 1'b0;
         if (clk_s == clk_flt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            flt_cnt <= '0;
            clk_flt <= clk_s;
            strobe  <= ~clk_s;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   assign timeout = (state != IDLE) && !strobe && (wdog == WW'(TIMEOUT_CYC));

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      good_c    = 1'b0;
      perr_c    = 1'b0;
      ferr_c    = 1'b0;
      if (timeout) begin
         state_nxt = IDLE;
         ferr_c    = 1'b1;
      end else if (strobe) begin
         case (state)
            IDLE:    if (!dat_s) state_nxt = DATA;
            DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP: begin
               state_nxt = IDLE;
               if (!odd_parity_ok(shreg, par_bit)) perr_c = 1'b1;
               else if (!dat_s)                   ferr_c = 1'b1;
               else                               good_c = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         wdog       <= '0;
         byte_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= good_c;
         parity_err <= perr_c;
         frame_err  <= ferr_c;

         if (strobe || timeout || state == IDLE) wdog <= '0;
         else                                    wdog <= wdog + 1'b1;

         if (strobe) begin
            case (state)
               IDLE: bit_cnt <= '0;
               DATA: begin
                  shreg   <= {dat_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY:  par_bit <= dat_s;
               default: ;
            endcase
         end
      end
   end

   assign byte_dat = shreg;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into key events and queues them in a show-ahead FIFO.
// Event visible 2 cycles after stop strobe; events arriving at full are dropped and flag overflow.
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 10000,
   parameter int DECODE      = 1
) (
   input  logic                          clk,
   input  logic                          clrn,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   input  logic                          rdn,
   output logic [7:0]                    ev_code,
   output logic                          ev_ext,
   output logic                          ev_brk,
   output logic                          ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic                          parity_err,
   output logic                          frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic       byte_valid;
   logic [7:0] byte_dat;
   logic       is_ext;
   logic       is_brk;
   logic       ext_pend;
   logic       brk_pend;
   logic       push_req;
   ps2_event_t push_ev;

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   ps2_event_t  mem [FIFO_DEPTH];
   ps2_event_t  head;

   ps2_frame_rx #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_frame (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .byte_dat   (byte_dat),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

   assign is_ext = (DECODE != 0) && (byte_dat == PS2_EXT);
   assign is_brk = (DECODE != 0) && (byte_dat == PS2_BRK);

   always_comb begin
      push_req     = byte_valid && !is_ext && !is_brk;
      push_ev.ext  = ext_pend;
      push_ev.brk  = brk_pend;
      push_ev.code = byte_dat;
   end

   // Pending prefixes are consumed by every non-prefix byte, even one dropped on full.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (parity_err || frame_err) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (byte_valid) begin
         if (is_ext) begin
            ext_pend <= 1'b1;
         end else if (is_brk) begin
            brk_pend <= 1'b1;
         end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop   = !rdn && !empty;
   // At full a simultaneous pop frees the slot being written this edge.
   assign push  = push_req && (!full || pop);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push_req && !push) overflow <= 1'b1;
         else if (pop)          overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= push_ev;
   end

   assign head    = mem[rptr[AW-1:0]];
   assign ev_code = empty ? 8'h00 : head.code;
   assign ev_ext  = empty ? 1'b0  : head.ext;
   assign ev_brk  = empty ? 1'b0  : head.brk;
   assign ready   = !empty;
   assign level   = wptr - rptr;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx; PS/2 bit period shortened to 40 clk cycles.
module tb_ps2_scancode_rx;
   import ps2_pkg::*;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rdn = 1'b1;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_brk;
   logic       ready;
   logic [3:0] level;
   logic       overflow;
   logic       parity_err;
   logic       frame_err;

   int checks = 0;
   int failures = 0;
   int perr_cnt = 0;
   int ferr_cnt = 0;
   int p0;
   int f0;
   logic [7:0] exp5 [8];

   ps2_scancode_rx dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rdn        (rdn),
      .ev_code    (ev_code),
      .ev_ext     (ev_ext),
      .ev_brk     (ev_brk),
      .ready      (ready),
      .level      (level),
      .overflow   (overflow),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (frame_err)  ferr_cnt <= ferr_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      cyc(10);
      ps2_clk = 1'b0;
      cyc(20);
      ps2_clk = 1'b1;
      cyc(10);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(b[i]);
   endtask

   // mode 0: plain frame; 1: check ready latency from stop strobe; 2: pop in the push cycle
   task automatic send_frame(input logic [7:0] b, input bit badp, input bit bads, input int mode);
      logic par;
      int   n;
      par = ~(^b) ^ badp;
      send_partial(b, 8);
      send_bit(par);
      ps2_data = ~bads;
      cyc(10);
      ps2_clk = 1'b0;
      n = 0;
      if (mode != 0) begin
         while (dut.u_frame.strobe !== 1'b1 && n < 30) begin
            cyc(1);
            n++;
         end
         chk("stop_strobe", dut.u_frame.strobe, 1);
         if (mode == 1) begin
            cyc(1);
            chk("ready_at_t1", ready, 0);
            cyc(1);
            chk("ready_at_t2", ready, 1);
         end else begin
            cyc(1);
            rdn = 1'b0;
            cyc(1);
            rdn = 1'b1;
         end
         n += 2;
      end
      cyc((n < 20) ? 20 - n : 1);
      ps2_clk = 1'b1;
      cyc(10);
   endtask

   task automatic pop_one();
      rdn = 1'b0;
      cyc(1);
      rdn = 1'b1;
      cyc(1);
   endtask

   initial begin
      exp5 = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B};

      // reset
      cyc(5);
      chk("reset_outputs", {ev_code, ev_ext, ev_brk, ready, level, overflow, parity_err, frame_err}, 0);
      clrn = 1'b1;
      cyc(5);

      // 1: single make code
      send_frame(8'h1C, 0, 0, 1);
      chk("t1_head", {ev_ext, ev_brk, ev_code}, 10'h01C);
      chk("t1_level", level, 1);
      pop_one();
      chk("t1_ready_after_pop", ready, 0);
      chk("t1_code_when_empty", ev_code, 0);

      // 2: prefix folding
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h1C, 0, 0, 0);
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h75, 0, 0, 0);
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'h75, 0, 0, 0);
      chk("t2_level", level, 3);
      chk("t2_ev0", {ev_ext, ev_brk, ev_code}, 10'h11C);
      pop_one();
      chk("t2_ev1", {ev_ext, ev_brk, ev_code}, 10'h375);
      pop_one();
      chk("t2_ev2", {ev_ext, ev_brk, ev_code}, 10'h275);
      pop_one();
      chk("t2_empty", ready, 0);

      // 3: parity errors
      p0 = perr_cnt;
      f0 = ferr_cnt;
      send_frame(8'h1C, 1, 0, 0);
      cyc(5);
      chk("t3_parity_pulses", perr_cnt - p0, 1);
      chk("t3_no_frame_err", ferr_cnt - f0, 0);
      chk("t3_ready", ready, 0);
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'h1C, 1, 0, 0);
      send_frame(8'h75, 0, 0, 0);
      chk("t3_prefix_cleared", {ev_ext, ev_brk, ev_code}, 10'h075);
      chk("t3_level", level, 1);
      pop_one();

      // 4: stop-bit error and watchdog
      p0 = perr_cnt;
      f0 = ferr_cnt;
      send_frame(8'h1C, 0, 1, 0);
      cyc(5);
      chk("t4_stop_frame_err", ferr_cnt - f0, 1);
      chk("t4_stop_no_parity", perr_cnt - p0, 0);
      chk("t4_stop_ready", ready, 0);
      f0 = ferr_cnt;
      send_partial(8'h5A, 5);
      cyc(9900);
      chk("t4_no_early_timeout", ferr_cnt - f0, 0);
      cyc(200);
      chk("t4_timeout_frame_err", ferr_cnt - f0, 1);
      chk("t4_state_idle", 32'(dut.u_frame.state), 32'(IDLE));
      send_frame(8'h29, 0, 0, 0);
      chk("t4_recover", {ev_ext, ev_brk, ev_code}, 10'h029);
      pop_one();

      // 5: overflow and push+pop at full
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
      chk("t5_level_full", level, 8);
      chk("t5_overflow", overflow, 1);
      chk("t5_head_01", {ev_ext, ev_brk, ev_code}, 10'h001);
      pop_one();
      chk("t5_overflow_cleared", overflow, 0);
      chk("t5_level_7", level, 7);
      chk("t5_head_02", ev_code, 8'h02);
      send_frame(8'h0A, 0, 0, 0);
      chk("t5_refill_level", level, 8);
      send_frame(8'h0B, 0, 0, 2);
      chk("t5_pushpop_level", level, 8);
      chk("t5_pushpop_overflow", overflow, 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t5_drain_%0d", i), ev_code, exp5[i]);
         pop_one();
      end
      chk("t5_drained", ready, 0);

      // 6: clock glitch rejection
      ps2_data = 1'b0;
      ps2_clk = 1'b0;
      cyc(2);
      ps2_clk = 1'b1;
      cyc(2);
      ps2_data = 1'b1;
      cyc(50);
      chk("t6_glitch_idle", 32'(dut.u_frame.state), 32'(IDLE));
      send_frame(8'h1C, 0, 0, 0);
      chk("t6_after_glitch", {ev_ext, ev_brk, ev_code}, 10'h01C);
      chk("t6_level", level, 1);
      pop_one();

      // 6: reset mid-frame
      send_frame(8'h29, 0, 0, 0);
      send_frame(8'hE0, 0, 0, 0);
      send_partial(8'h1C, 5);
      clrn = 1'b0;
      #1;
      chk("t6_async_reset", {ev_code, ev_ext, ev_brk, ready, level, overflow, parity_err, frame_err}, 0);
      chk("t6_reset_state", 32'(dut.u_frame.state), 32'(IDLE));
      cyc(3);
      clrn = 1'b1;
      cyc(5);
      send_frame(8'h75, 0, 0, 0);
      chk("t6_post_reset", {ev_ext, ev_brk, ev_code}, 10'h075);
      chk("t6_post_reset_level", level, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
